// File: rtl/int_gen_responder.sv
// Memory-mapped countdown interrupt source with CPU acknowledge (ACK/CTRL/DELAY/STATUS window).
// Optional macro INT_EXT_REQ_EN adds a synchronized external request input that forces PEND.
//
// state | meaning
// IDLE  | disarmed, interrupt low
// COUNT | countdown running, cnt = edges left until interrupt
// PEND  | interrupt high, waiting for ACK
module int_gen_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
    parameter int          DELAY_W   = 16
) (
`ifdef INT_EXT_REQ_EN
    input  logic        ext_req,
`endif
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PEND  = 2'd2
    } state_t;

    localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

    state_t             state_q;
    logic [1:0]         ctrl_q;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] cnt_q;
    logic               irq_q;
    logic               ext_flag_q;
    logic               ext_hit;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    logic               hit;
    logic               we;
    logic               ack_wr;
    logic               ctrl_wr;
    logic               delay_wr;
    logic [31:0]        ctrl_new;
    logic [31:0]        delay_new;
    logic [DELAY_W-1:0] reload;
    logic               unused_bits;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign we        = hit && (byteen != 4'b0000);
    assign ack_wr    = we && (addr[3:2] == 2'd0);
    assign ctrl_wr   = we && (addr[3:2] == 2'd1);
    assign delay_wr  = we && (addr[3:2] == 2'd2);
    assign ctrl_new  = merge_lanes({30'b0, ctrl_q}, wdata, byteen);
    assign delay_new = merge_lanes({{(32-DELAY_W){1'b0}}, delay_q}, wdata, byteen);
    // A zero DELAY still takes one edge so the interrupt is never raised on the arming edge.
    assign reload    = (delay_q == '0) ? CNT_ONE : delay_q;
    assign unused_bits = ^{addr[1:0], ctrl_new[31:2], delay_new[31:DELAY_W]};

`ifdef INT_EXT_REQ_EN
    logic ext_s1_q, ext_s2_q, ext_s3_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_s1_q <= 1'b0;
            ext_s2_q <= 1'b0;
            ext_s3_q <= 1'b0;
        end else begin
            ext_s1_q <= ext_req;
            ext_s2_q <= ext_s1_q;
            ext_s3_q <= ext_s2_q;
        end
    end

    assign ext_hit = ext_s2_q && !ext_s3_q && ctrl_q[0];
`else
    assign ext_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 2'b00;
            delay_q    <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            ext_flag_q <= 1'b0;
        end else begin
            if (delay_wr) delay_q <= delay_new[DELAY_W-1:0];
            if (ctrl_wr)  ctrl_q  <= ctrl_new[1:0];
            case (state_q)
                IDLE: begin
                    if (ctrl_wr && ctrl_new[0]) begin
                        state_q <= COUNT;
                        cnt_q   <= reload;
                    end
                end
                COUNT: begin
                    if (ctrl_wr) begin
                        if (!ctrl_new[0]) state_q <= IDLE;
                        else              cnt_q   <= reload;
                    end else if (ext_hit) begin
                        state_q    <= PEND;
                        irq_q      <= 1'b1;
                        ext_flag_q <= 1'b1;
                    end else if (cnt_q == CNT_ONE) begin
                        state_q <= PEND;
                        irq_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                PEND: begin
                    // A disabling CTRL write wins over an ACK; an enabling one only updates MODE.
                    if (ctrl_wr) begin
                        if (!ctrl_new[0]) begin
                            state_q <= IDLE;
                            irq_q   <= 1'b0;
                        end
                    end else if (ack_wr) begin
                        irq_q      <= 1'b0;
                        ext_flag_q <= 1'b0;
                        if (ctrl_q[1]) begin
                            state_q <= COUNT;
                            cnt_q   <= reload;
                        end else begin
                            state_q   <= IDLE;
                            ctrl_q[0] <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (addr[3:2])
                2'd1: rdata = {30'b0, ctrl_q};
                2'd2: rdata = {{(32-DELAY_W){1'b0}}, delay_q};
                2'd3: begin
                    rdata[1:0]            = state_q;
                    rdata[2]              = irq_q;
                    rdata[3]              = ext_flag_q;
                    rdata[DELAY_W+15:16]  = cnt_q;
                end
                default: rdata = 32'h0;
            endcase
        end
    end

    assign interrupt = irq_q;

endmodule

// File: tb/tb_int_gen_responder.sv
// Scoreboard bench for int_gen_responder: a timeline model (arm edge + delay = fire edge) predicts
// interrupt every cycle and rdata on reads; a negedge monitor pops and compares.
module tb_int_gen_responder;

    localparam logic [31:0] BASE = 32'h0000_7F20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        interrupt;
`ifdef INT_EXT_REQ_EN
    logic        ext_req;
`endif

    int checks = 0;
    int errors = 0;

    int_gen_responder dut (
`ifdef INT_EXT_REQ_EN
        .ext_req   (ext_req),
`endif
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .byteen    (byteen),
        .wdata     (wdata),
        .rdata     (rdata),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] rdv;
        logic        irq;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model: the countdown is a fire time on the edge timeline.
    int          cyc;
    bit          m_active;
    int          m_fire;
    int          m_pend_cnt;
    int          m_cnt_idle;
    bit          m_en, m_mode, m_flag;
    logic [15:0] m_delay;
    int          m_ext_edge;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic bit m_pending();
        return m_active && (cyc >= m_fire);
    endfunction

    function automatic int reload_len();
        return (m_delay == 16'd0) ? 1 : int'(m_delay);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        int          st, cnt;
        r = 32'h0;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd1: r = {30'b0, m_mode, m_en};
                2'd2: r = {16'b0, m_delay};
                2'd3: begin
                    if (!m_active)       begin st = 0; cnt = m_cnt_idle; end
                    else if (m_pending()) begin st = 2; cnt = m_pend_cnt; end
                    else                  begin st = 1; cnt = m_fire - cyc; end
                    r = st + (int'(m_pending()) << 2) + (int'(m_flag) << 3) + (cnt << 16);
                end
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_active = 0; m_fire = 0; m_pend_cnt = 0; m_cnt_idle = 0;
        m_en = 0; m_mode = 0; m_flag = 0; m_delay = 16'd0; m_ext_edge = -1;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int          e;
        bit          pend, hit, cw, ack, dw;
        logic [31:0] mg;
        e    = cyc + 1;
        pend = m_pending();
        hit  = (a[31:4] == BASE[31:4]) && (be != 4'b0);
        cw   = hit && (a[3:2] == 2'd1);
        ack  = hit && (a[3:2] == 2'd0);
        dw   = hit && (a[3:2] == 2'd2);
        if (cw) begin
            mg = merge({30'b0, m_mode, m_en}, wd, be);
            m_en = mg[0]; m_mode = mg[1];
            if (!m_en) begin
                if (m_active) m_cnt_idle = pend ? m_pend_cnt : m_fire - (e - 1);
                m_active = 0;
            end else if (!m_active || !pend) begin
                m_active = 1; m_fire = e + reload_len(); m_pend_cnt = 1;
            end
        end else if (ack && pend) begin
            m_flag = 0;
            if (m_mode) begin
                m_fire = e + reload_len(); m_pend_cnt = 1;
            end else begin
                m_active = 0; m_en = 0; m_cnt_idle = m_pend_cnt;
            end
        end else if (m_active && !pend && m_en && (m_ext_edge == e)) begin
            m_pend_cnt = m_fire - (e - 1); m_fire = e; m_flag = 1;
        end
        if (dw) begin
            mg = merge({16'b0, m_delay}, wd, be);
            m_delay = mg[15:0];
        end
    endtask

    // One bus cycle, entered and left at posedge+1.
    task automatic cycle(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input bit rd);
        exp_t x;
        addr = a; byteen = be; wdata = wd;
        x.rd = rd; x.rdv = m_read(a); x.irq = m_pending(); x.cyc = cyc;
        sb.push_back(x);
        model_step(a, be, wd);
        @(posedge clk);
        cyc++;
        #1;
        byteen = 4'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [3:0] be, input logic [31:0] d);
        cycle(BASE + 32'(off), be, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] off);
        cycle(BASE + 32'(off), 4'b0, 32'h0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (interrupt !== x.irq) begin
                    errors++;
                    $display("FAIL irq cyc=%0d got=%b exp=%b", x.cyc, interrupt, x.irq);
                end
                if (x.rd) begin
                    checks++;
                    if (rdata !== x.rdv) begin
                        errors++;
                        $display("FAIL rdata cyc=%0d addr=%h got=%h exp=%h", x.cyc, addr, rdata, x.rdv);
                    end
                end
            end
        end
    end

    initial begin : stim
        int          r, w;
        logic [31:0] a;
        reset = 1'b0; addr = BASE + 32'h4; byteen = 4'b0; wdata = 32'h0;
`ifdef INT_EXT_REQ_EN
        ext_req = 1'b0;
`endif
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {31'b0, interrupt}, 32'h0);
        chk("reset_ctrl", rdata, 32'h0);
        addr = BASE + 32'hC; #1;
        chk("reset_status", rdata, 32'h0);
        reset = 1'b1;

        // one-shot, DELAY=3
        wr(4'h8, 4'hF, 32'd3); wr(4'h4, 4'hF, 32'd1);
        repeat (4) rd(4'hC);
        wr(4'h0, 4'hF, 32'h0); rd(4'hC); rd(4'h4);

        // periodic, DELAY=2, three periods with ACK at +5
        wr(4'h8, 4'hF, 32'd2); wr(4'h4, 4'hF, 32'd3);
        repeat (3) begin
            repeat (4) rd(4'hC);
            wr(4'h0, 4'hF, 32'h0);
        end
        wr(4'h4, 4'hF, 32'd0); rd(4'hC);

        // DELAY=0 fires after one edge; ACK while counting is ignored
        wr(4'h8, 4'hF, 32'd0); wr(4'h4, 4'hF, 32'd1); rd(4'hC); rd(4'hC);
        wr(4'h0, 4'hF, 32'h0); rd(4'h4);
        wr(4'h8, 4'hF, 32'd5); wr(4'h4, 4'hF, 32'd1); rd(4'hC);
        wr(4'h0, 4'hF, 32'h0);
        repeat (4) rd(4'hC);
        wr(4'h0, 4'hF, 32'h0); rd(4'hC);

        // partial / null / out-of-window writes
        wr(4'h8, 4'hF, 32'd0);
        wr(4'h8, 4'b0001, 32'hAABB_CCDD); rd(4'h8);
        wr(4'h8, 4'b0000, 32'hFFFF_FFFF); rd(4'h8);
        cycle(BASE + 32'h10, 4'hF, 32'h0000_1234, 1'b0); rd(4'h8);
        cycle(BASE + 32'h14, 4'hF, 32'h0000_0003, 1'b0); rd(4'h4);

        // disable while pending
        wr(4'h8, 4'hF, 32'd2); wr(4'h4, 4'hF, 32'd1);
        repeat (3) rd(4'hC);
        wr(4'h4, 4'hF, 32'd0); rd(4'hC); rd(4'hC);

`ifdef INT_EXT_REQ_EN
        wr(4'h8, 4'hF, 32'd20); wr(4'h4, 4'hF, 32'd1); rd(4'hC);
        ext_req = 1'b1; m_ext_edge = cyc + 3;
        repeat (4) rd(4'hC);
        ext_req = 1'b0; m_ext_edge = -1;
        rd(4'hC); wr(4'h0, 4'hF, 32'h0); rd(4'hC);
`endif

        // async reset mid-count
        wr(4'h8, 4'hF, 32'd4); wr(4'h4, 4'hF, 32'd3); rd(4'hC); rd(4'hC);
        addr = BASE + 32'h4; byteen = 4'b0;
        reset = 1'b0; #1;
        chk("midrst_irq", {31'b0, interrupt}, 32'h0);
        chk("midrst_ctrl", rdata, 32'h0);
        addr = BASE + 32'hC; #1;
        chk("midrst_status", rdata, 32'h0);
        model_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); cyc++; #1;
        rd(4'h4); rd(4'hC);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 3);
            a = BASE | 32'(w << 2) | 32'($urandom_range(0, 3));
            case (r)
                0, 1, 2: cycle(a, 4'b0, 32'h0, 1'b1);
                3:       wr(4'h0, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 15), $urandom);
                4, 5:    wr(4'h4, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 15),
                            32'($urandom_range(0, 3)));
                6:       wr(4'h8, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 12)));
                7:       cycle(BASE ^ (32'h1 << $urandom_range(4, 31)), 4'hF, $urandom, 1'b0);
                default: rd(4'hC);
            endcase
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
